// File: rtl/kaiserlake_pkg.sv
// rtl/kaiserlake_pkg.sv - shared fetch-stage types and constants
//
// Purpose : widths, the NOP/HALT encodings and the fetch FSM state type
//           used by pipeline_f_fetch and fetch_skid_buffer.
// Ports   : none (package).
package kaiserlake_pkg;

   localparam int PC_W = 8;
   localparam int IR_W = 16;

   localparam logic [IR_W-1:0] NOP_INST = 16'h0000;
   localparam logic [2:0]      OPC_HALT = 3'b111;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALTED
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry {IR, PC} holding register for stalled responses
//
// Purpose : parks a memory response that arrived while decode was stalled.
// Ports   : clk, rst      clock, asynchronous active-high reset
//           clear_in      drop any held word (highest priority)
//           load_in       capture ir_in/pc_in, buffer becomes full
//           unload_in     buffer becomes empty
//           ir_in, pc_in  word to capture
//           full_out      buffer holds a word
//           ir_out,pc_out held word
module fetch_skid_buffer
   import kaiserlake_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clear_in,
   input  logic            load_in,
   input  logic            unload_in,
   input  logic [IR_W-1:0] ir_in,
   input  logic [PC_W-1:0] pc_in,
   output logic            full_out,
   output logic [IR_W-1:0] ir_out,
   output logic [PC_W-1:0] pc_out
);

   logic            full_q, full_d;
   logic [IR_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0] pc_q, pc_d;

   // A load while full replaces the held word: the caller unloads the old
   // word in the same cycle it loads the new one.
   always_comb begin
      full_d = full_q;
      ir_d   = ir_q;
      pc_d   = pc_q;
      if (clear_in) begin
         full_d = 1'b0;
      end else if (load_in) begin
         full_d = 1'b1;
         ir_d   = ir_in;
         pc_d   = pc_in;
      end else if (unload_in) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         ir_q   <= NOP_INST;
         pc_q   <= '0;
      end else begin
         full_q <= full_d;
         ir_q   <= ir_d;
         pc_q   <= pc_d;
      end
   end

   assign full_out = full_q;
   assign ir_out   = ir_q;
   assign pc_out   = pc_q;

endmodule

// File: rtl/pipeline_f_fetch.sv
// rtl/pipeline_f_fetch.sv - instruction fetch stage with stall skid and redirect
//
// Purpose : holds the PC, drives a synchronous 8-bit-address / 16-bit-data
//           instruction memory and hands {IR, PC} to decode.
// Macro   : FETCH_HALT_EN - stop fetching when a word with [15:13]=111 returns.
// Ports   : clk, rst                 clock, asynchronous active-high reset
//           stall_in                 decode cannot accept; output registers hold
//           redirect_in              taken branch; flush and refetch
//           redirect_pc_in           branch target
//           mem_rd_out, mem_addr_out memory read request / address
//           mem_rdata_in             read data, one cycle after the request
//           IR_out, PC_out           instruction and its address
//           valid_out                IR_out/PC_out hold a real instruction
//           halted_out               fetch stopped on HALT
module pipeline_f_fetch
   import kaiserlake_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_in,
   input  logic            redirect_in,
   input  logic [PC_W-1:0] redirect_pc_in,
   output logic            mem_rd_out,
   output logic [PC_W-1:0] mem_addr_out,
   input  logic [IR_W-1:0] mem_rdata_in,
   output logic [IR_W-1:0] IR_out,
   output logic [PC_W-1:0] PC_out,
   output logic            valid_out,
   output logic            halted_out
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic            inflight_q, inflight_d;
   logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
   logic [IR_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic            halted_q, halted_d;

   logic            redirect_ok;
   logic            halt_resp;
   logic            resp_fwd;
   logic            skid_clear, skid_load, skid_unload;
   logic            skid_full;
   logic [IR_W-1:0] skid_ir;
   logic [PC_W-1:0] skid_pc;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      ir_d          = ir_q;
      pc_d          = pc_q;
      valid_d       = valid_q;
      halted_d      = halted_q;
      skid_clear    = 1'b0;
      skid_load     = 1'b0;
      skid_unload   = 1'b0;

      redirect_ok = redirect_in && (state_q != BOOT);

`ifdef FETCH_HALT_EN
      halt_resp = inflight_q && (mem_rdata_in[IR_W-1 -: 3] == OPC_HALT);
`else
      halt_resp = 1'b0;
`endif
      resp_fwd = inflight_q && !halt_resp;

      // A returning HALT also suppresses the request that would otherwise
      // be issued alongside it, so nothing trails the HALT into memory.
      mem_rd_out   = redirect_ok || ((state_q == RUN) && !stall_in && !halt_resp);
      mem_addr_out = redirect_ok ? redirect_pc_in : fetch_pc_q;

      inflight_d    = mem_rd_out;
      inflight_pc_d = mem_addr_out;
      if (mem_rd_out) begin
         fetch_pc_d = mem_addr_out + 8'd1;
      end

      if (state_q == BOOT) begin
         state_d = RUN;
      end

      if (redirect_ok) begin
         state_d    = RUN;
         halted_d   = 1'b0;
         skid_clear = 1'b1;
         valid_d    = 1'b0;
         ir_d       = NOP_INST;
      end else begin
         if (halt_resp) begin
            state_d  = HALTED;
            halted_d = 1'b1;
         end
         if (stall_in) begin
            if (resp_fwd) begin
               skid_load = 1'b1;
            end
         end else if (skid_full) begin
            // Older parked word goes out first; a fresh response takes its slot.
            ir_d    = skid_ir;
            pc_d    = skid_pc;
            valid_d = 1'b1;
            if (resp_fwd) begin
               skid_load = 1'b1;
            end else begin
               skid_unload = 1'b1;
            end
         end else if (resp_fwd) begin
            ir_d    = mem_rdata_in;
            pc_d    = inflight_pc_q;
            valid_d = 1'b1;
         end else begin
            ir_d    = NOP_INST;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= BOOT;
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         ir_q          <= NOP_INST;
         pc_q          <= '0;
         valid_q       <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         ir_q          <= ir_d;
         pc_q          <= pc_d;
         valid_q       <= valid_d;
         halted_q      <= halted_d;
      end
   end

   fetch_skid_buffer u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear_in  (skid_clear),
      .load_in   (skid_load),
      .unload_in (skid_unload),
      .ir_in     (mem_rdata_in),
      .pc_in     (inflight_pc_q),
      .full_out  (skid_full),
      .ir_out    (skid_ir),
      .pc_out    (skid_pc)
   );

   assign IR_out     = ir_q;
   assign PC_out     = pc_q;
   assign valid_out  = valid_q;
   assign halted_out = halted_q;

endmodule

// File: tb/tb_pipeline_f_fetch.sv
// tb/tb_pipeline_f_fetch.sv - self-checking bench for pipeline_f_fetch
module tb_pipeline_f_fetch;

`ifdef FETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_in = 1'b0;
   logic        redirect_in = 1'b0;
   logic [7:0]  redirect_pc_in = 8'h00;
   logic        mem_rd_out;
   logic [7:0]  mem_addr_out;
   logic [15:0] mem_rdata_in = 16'h0000;
   logic [15:0] IR_out;
   logic [7:0]  PC_out;
   logic        valid_out;
   logic        halted_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] mem [0:255];

   pipeline_f_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .stall_in       (stall_in),
      .redirect_in    (redirect_in),
      .redirect_pc_in (redirect_pc_in),
      .mem_rd_out     (mem_rd_out),
      .mem_addr_out   (mem_addr_out),
      .mem_rdata_in   (mem_rdata_in),
      .IR_out         (IR_out),
      .PC_out         (PC_out),
      .valid_out      (valid_out),
      .halted_out     (halted_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_out) mem_rdata_in <= mem[mem_addr_out];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: words requested are delivered one edge after the request into an
   // unbounded FIFO of fetched words; decode pops one per unstalled edge.
   typedef struct {
      logic [15:0] ir;
      logic [7:0]  pc;
   } word_t;

   word_t       m_q[$];
   bit          m_started = 0;
   bit          m_halted  = 0;
   bit          m_pend_v  = 0;
   logic [7:0]  m_pend_pc = 8'h00;
   logic [15:0] m_pend_ir = 16'h0000;
   logic [7:0]  m_next_pc = 8'h00;
   bit          m_out_v   = 0;
   logic [7:0]  m_out_pc  = 8'h00;
   logic [15:0] m_out_ir  = 16'h0000;

   function automatic bit m_halt_arriving();
      return HALT_EN && m_pend_v && (m_pend_ir[15:13] == 3'b111) && !redirect_in;
   endfunction

   function automatic bit m_req();
      return m_started && (redirect_in || (!m_halted && !stall_in && !m_halt_arriving()));
   endfunction

   function automatic logic [7:0] m_addr();
      return redirect_in ? redirect_pc_in : m_next_pc;
   endfunction

   task automatic model_step();
      bit         req;
      logic [7:0] addr;
      word_t      w;
      if (rst) begin
         m_q.delete();
         m_started = 0; m_halted = 0; m_pend_v = 0;
         m_next_pc = 8'h00; m_out_v = 0; m_out_pc = 8'h00; m_out_ir = 16'h0000;
         return;
      end
      if (!m_started) begin
         m_started = 1;
         return;
      end
      req  = m_req();
      addr = m_addr();
      if (redirect_in) begin
         m_q.delete();
         m_out_v  = 0;
         m_out_ir = 16'h0000;
         m_halted = 0;
      end else begin
         if (m_pend_v) begin
            if (HALT_EN && m_pend_ir[15:13] == 3'b111) m_halted = 1;
            else begin
               w.ir = m_pend_ir;
               w.pc = m_pend_pc;
               m_q.push_back(w);
            end
         end
         if (!stall_in) begin
            if (m_q.size() > 0) begin
               w = m_q.pop_front();
               m_out_v = 1; m_out_pc = w.pc; m_out_ir = w.ir;
            end else begin
               m_out_v = 0; m_out_ir = 16'h0000;
            end
         end
      end
      m_pend_v = req;
      if (req) begin
         m_pend_pc = addr;
         m_pend_ir = mem[addr];
         m_next_pc = addr + 8'd1;
      end
   endtask

   always @(posedge clk or posedge rst) model_step();

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         check("mem_rd", mem_rd_out, m_req());
         if (m_req()) check("mem_addr", mem_addr_out, m_addr());
         check("valid", valid_out, m_out_v);
         check("ir", IR_out, m_out_v ? m_out_ir : 16'h0000);
         if (m_out_v) check("pc", PC_out, m_out_pc);
         check("halted", halted_out, m_halted);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [7:0] pc);
      check({name, "_valid"}, valid_out, 1'b1);
      check({name, "_pc"}, PC_out, pc);
      check({name, "_ir"}, IR_out, 16'hC000 | {8'h00, pc});
   endtask

   task automatic expect_bubble(input string name);
      check({name, "_valid"}, valid_out, 1'b0);
      check({name, "_ir"}, IR_out, 16'h0000);
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | i[15:0];
      mem[8'h30] = 16'hE030;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_ir", IR_out, 16'h0000);
      check("rst_pc", PC_out, 8'h00);
      check("rst_valid", valid_out, 1'b0);
      check("rst_halted", halted_out, 1'b0);
      check("rst_mem_rd", mem_rd_out, 1'b0);

      tick();                                  // E0: BOOT -> RUN
      check("e0_mem_rd", mem_rd_out, 1'b1);
      check("e0_mem_addr", mem_addr_out, 8'h00);
      expect_bubble("e0");
      tick();                                  // E1
      expect_bubble("e1");
      tick();                                  // E2
      expect_out("e2", 8'h00);
      tick(); expect_out("seq1", 8'h01);
      tick(); expect_out("seq2", 8'h02);

      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (valid_out && PC_out == 8'h05) found = 1;
         else tick();
      end
      check("reach_pc5", found, 1'b1);

      stall_in = 1'b1;
      repeat (3) begin
         tick();
         expect_out("stall_hold", 8'h05);
      end
      stall_in = 1'b0;
      tick(); expect_out("rel6", 8'h06);
      tick(); expect_out("rel7", 8'h07);
      tick(); expect_out("rel8", 8'h08);

      redirect_in = 1'b1; redirect_pc_in = 8'h40;
      #1;
      check("redir_mem_rd", mem_rd_out, 1'b1);
      check("redir_mem_addr", mem_addr_out, 8'h40);
      tick(); expect_bubble("redir_bubble");
      redirect_in = 1'b0;
      tick(); expect_out("redir40", 8'h40);
      tick(); expect_out("redir41", 8'h41);

      redirect_in = 1'b1; redirect_pc_in = 8'hFC;
      tick(); redirect_in = 1'b0;
      tick(); expect_out("wrapFC", 8'hFC);
      tick(); tick();
      expect_out("wrapFE", 8'hFE);
      tick(); expect_out("wrapFF", 8'hFF);
      tick(); expect_out("wrap00", 8'h00);

      stall_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = 8'h20;
      #1;
      check("rs_mem_rd", mem_rd_out, 1'b1);
      check("rs_mem_addr", mem_addr_out, 8'h20);
      tick(); expect_bubble("rs_bubble");
      stall_in = 1'b0; redirect_in = 1'b0;
      tick(); expect_out("rs20", 8'h20);
      stall_in = 1'b1;
      tick(); expect_out("rs_hold1", 8'h20);
      tick(); expect_out("rs_hold2", 8'h20);
      stall_in = 1'b0;
      tick(); expect_out("rs21", 8'h21);
      tick(); expect_out("rs22", 8'h22);

`ifdef FETCH_HALT_EN
      mem[3] = 16'hE000;
      redirect_in = 1'b1; redirect_pc_in = 8'h00;
      tick(); redirect_in = 1'b0;
      tick(); expect_out("h0", 8'h00);
      tick(); expect_out("h1", 8'h01);
      tick(); expect_out("h2", 8'h02);
      check("h2_mem_rd", mem_rd_out, 1'b0);
      tick();
      expect_bubble("halt");
      check("halt_flag", halted_out, 1'b1);
      repeat (3) begin
         tick();
         check("halt_no_rd", mem_rd_out, 1'b0);
         check("halt_stays", halted_out, 1'b1);
      end
      redirect_in = 1'b1; redirect_pc_in = 8'h00;
      #1;
      check("unhalt_mem_rd", mem_rd_out, 1'b1);
      tick();
      redirect_in = 1'b0;
      check("unhalt_flag", halted_out, 1'b0);
      tick(); expect_out("unhalt0", 8'h00);
`else
      redirect_in = 1'b1; redirect_pc_in = 8'h30;
      tick(); redirect_in = 1'b0;
      tick();
      check("opc111_valid", valid_out, 1'b1);
      check("opc111_pc", PC_out, 8'h30);
      check("opc111_ir", IR_out, 16'hE030);
      check("opc111_halted", halted_out, 1'b0);
      tick(); expect_out("opc111_next", 8'h31);
`endif

      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/pipeline_f_fetch.md
# pipeline_f_fetch

Instruction fetch stage. Holds the program counter and drives an 8-bit-addressed, 16-bit-wide synchronous instruction memory. It delivers `{IR, PC}` pairs to the combinational decode stage, which sits directly downstream. It absorbs downstream stalls without dropping a fetched word and obeys branch redirects from later stages.

## Interface
- `RESET_PC`, default `8'h00`: first fetch address after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_in`  in  1  decode/hazard stage cannot accept a new instruction; output registers hold.
- `redirect_in`  in  1  branch/BX/BL/BLX resolved taken; flush and refetch.
- `redirect_pc_in`  in  8  target address, valid when `redirect_in`=1.
- `mem_rd_out`  out  1  memory read request this cycle.
- `mem_addr_out`  out  8  read address, valid when `mem_rd_out`=1.
- `mem_rdata_in`  in  16  read data, valid exactly one cycle after the request.
- `IR_out`  out  16  instruction to decode; `16'h0000` (NOP) whenever `valid_out`=0.
- `PC_out`  out  8  address of `IR_out`.
- `valid_out`  out  1  `IR_out`/`PC_out` hold a real instruction.
- `halted_out`  out  1  fetch stopped on HALT (only with `FETCH_HALT_EN`, otherwise tied 0).

## Operation
- FSM states are `BOOT`, `RUN`, and `HALTED`. Reset enters `BOOT`. `BOOT`→`RUN` unconditionally on the first edge after reset deasserts.
- Reset values:
  - `IR_out`=0, `PC_out`=0, `valid_out`=0, `halted_out`=0.
  - `mem_rd_out`=0. `mem_addr_out` may show `fetch_pc`, which resets to `RESET_PC`.
  - Skid buffer empty; in-flight flag 0.
- Request in `RUN`:
  - `mem_rd_out` = `RUN & !stall_in & !redirect_in`.
  - `mem_addr_out` = `fetch_pc`.
  - On issue, `fetch_pc` ← `fetch_pc`+1, mod 256 (`8'hFF` wraps to `8'h00`).
  - In-flight flag and in-flight PC are registered.
- Redirect has the highest priority and applies in any state except `BOOT`:
  - `mem_rd_out`=1 and `mem_addr_out`=`redirect_pc_in` in the same cycle.
  - `fetch_pc` ← `redirect_pc_in`+1.
  - The in-flight response from the previous cycle is discarded, the skid buffer is cleared, and the output is cleared (`valid_out`=0, `IR_out`=0).
  - State ← `RUN`, and `halted_out` clears.
  - Redirect overrides a simultaneous `stall_in`.
- Response, when the in-flight flag is set:
  - If `!stall_in`, the word loads into the output registers. If the skid buffer is full, the skid word loads instead and the response moves into the skid buffer.
  - If `stall_in`, the response is captured in the skid buffer.
  - Because issue is gated by `stall_in`, at most one word is ever in flight. A 1-entry skid buffer is therefore sufficient, and overflow is impossible.
- Stall:
  - Output registers hold their value while `stall_in`=1.
  - When no word is available after a stall release, `valid_out`←0 and `IR_out`←0.
- Instruction order out is always strictly sequential between redirects. No word is duplicated or lost.

## Timing
- Reset deasserted before edge E0:
  - E0: `BOOT`→`RUN`.
  - Cycle after E0: request for `RESET_PC`.
  - E2: `valid_out`=1 with `PC_out`=`RESET_PC`.
- Steady state: one instruction per cycle. Latency is 2 edges from request issue to output.
- Redirect asserted in cycle N: target instruction valid at the output after edge N+2. Bubble output during N+1.
- Stall asserted for k cycles and then released: output resumes on the next edge using the skid word, with no bubble.

## Configuration
- `FETCH_HALT_EN` defined: a returning word with `[15:13]`=`3'b111` is not forwarded.
  - Output becomes NOP with `valid_out`=0.
  - `halted_out`←1 and state ← `HALTED`. No further requests are made.
  - Only `rst` or `redirect_in` leaves `HALTED`.
- `FETCH_HALT_EN` undefined: opcode `111` passes through as an ordinary word, `HALTED` is unreachable, and `halted_out`=0.

## Structure
- Shared package `kaiserlake_pkg` holds:
  - `PC_W`=8 and `IR_W`=16.
  - `NOP_INST`=`16'h0000`.
  - `OPC_HALT`=`3'b111`.
  - `fetch_state_t` enum `{BOOT, RUN, HALTED}`.
- One sub-module, `fetch_skid_buffer`: a 1-entry `{IR, PC}` register with a full flag, plus load, unload, and clear controls.

## Test plan
- Reset, then run with memory `mem[i]`=`16'hC000|i` and no stall → after E2, one word per cycle: `PC_out`=0,1,2,… and `IR_out`=`mem[PC]`.
- Hold `stall_in` high for 3 cycles mid-stream at `PC_out`=5 → the output holds 5; after release it emits 6, 7, 8 on consecutive edges, with no gap and no duplicate.
- Assert `redirect_in` with target `8'h40` while word 9 is in flight → word 9 never appears, one bubble (`IR_out`=0, `valid_out`=0), then `PC_out`=`8'h40`, `8'h41`.
- Run sequentially past `8'hFF` → `PC_out` goes `8'hFE`, `8'hFF`, `8'h00`.
- Assert `redirect_in` and `stall_in` in the same cycle → the redirect wins, the target is fetched, and the target instruction is valid at the output after N+2 (output holds it while stall persists).
- With `FETCH_HALT_EN`, `mem[3]`=`16'hE000` → `PC_out` 0–2 valid, then `halted_out`=1 and `mem_rd_out` stays 0. A later redirect to 0 resumes fetch and clears `halted_out`.
